// File: rtl/m6809_pkg.sv
// Shared types for the 6809-style word transfer engine: FSM states and bus R/W levels.
package m6809_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic BUS_READ  = 1'b1;
  localparam logic BUS_WRITE = 1'b0;

endpackage

// File: rtl/m6809_word_xfer.sv
// Splits a 16-bit load/store into two big-endian byte cycles on an 8-bit 6809-style bus.
// Optional macro M6809_BUS_READY_EN lets bus_ready stretch byte cycles; otherwise it is ignored.
module m6809_word_xfer
  import m6809_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic [15:0]       rdata,
  output logic              n_out,
  output logic              z_out,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_rw,
  output logic              bus_vma,
  output logic [7:0]        bus_dout,
  input  logic [7:0]        bus_din,
  input  logic              bus_ready
);

  state_t            state, state_nxt;
  logic              wr_q;
  logic [ADDR_W-1:0] base_q;
  logic [15:0]       wdata_q;
  logic [7:0]        hi_q;
  logic              rdy;
  logic [15:0]       load_word;

`ifdef M6809_BUS_READY_EN
  assign rdy = bus_ready;
`else
  logic unused_bus_ready;
  assign unused_bus_ready = bus_ready;
  assign rdy = 1'b1;
`endif

  assign load_word = {hi_q, bus_din};

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      wr_q    <= 1'b0;
      base_q  <= '0;
      wdata_q <= '0;
      hi_q    <= '0;
      rdata   <= '0;
      n_out   <= 1'b0;
      z_out   <= 1'b1;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start) begin
          wr_q    <= wr;
          base_q  <= addr;
          wdata_q <= wdata;
        end
        HI: if (rdy && !wr_q) hi_q <= bus_din;
        // Result flags land on the LO->DONE edge so they are valid alongside done.
        LO: if (rdy) begin
          if (wr_q) begin
            n_out <= wdata_q[15];
            z_out <= (wdata_q == 16'h0000);
          end else begin
            rdata <= load_word;
            n_out <= load_word[15];
            z_out <= (load_word == 16'h0000);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    bus_vma   = 1'b0;
    bus_rw    = BUS_READ;
    bus_dout  = 8'h00;
    bus_addr  = '0;
    case (state)
      IDLE: if (start) state_nxt = HI;
      HI: begin
        busy     = 1'b1;
        bus_vma  = 1'b1;
        bus_addr = base_q;
        bus_rw   = wr_q ? BUS_WRITE : BUS_READ;
        bus_dout = wr_q ? wdata_q[15:8] : 8'h00;
        if (rdy) state_nxt = LO;
      end
      LO: begin
        busy     = 1'b1;
        bus_vma  = 1'b1;
        bus_addr = base_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        bus_rw   = wr_q ? BUS_WRITE : BUS_READ;
        bus_dout = wr_q ? wdata_q[7:0] : 8'h00;
        if (rdy) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
